// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: samples, then binary-searches the DAC code MSB-first
// using the comparator decision, and hands the result over a valid/ready handshake.
// Optional macro SAR_CMP_SYNC_EN adds a 2-flop synchronizer on cmp_in and widens each bit's hold window by 2.
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample,
    output logic             cmp_en,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready
);

    logic cmp_bit;

`ifdef SAR_CMP_SYNC_EN
    // Two extra hold clocks let the synchronized decision catch up with the current trial code.
    localparam int HOLD = SETTLE_CYCLES + 2;
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], cmp_in};
        end
    end

    assign cmp_bit = sync_q[1];
`else
    localparam int HOLD = SETTLE_CYCLES;
    assign cmp_bit = cmp_in;
`endif

    localparam int MAXC = (HOLD > SAMPLE_CYCLES) ? HOLD : SAMPLE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_TRIAL   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0]    HOLD_LOAD   = CW'(HOLD - 1);
    localparam logic [IW-1:0]    TOP_BIT     = IW'(WIDTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SAMPLE, ST_CONV, ST_DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    bit_q;
    logic             sample_q;
    logic             cmp_en_q;
    logic             busy_q;
    logic             valid_q;
    logic [WIDTH-1:0] dac_q;
    logic [WIDTH-1:0] result_q;

    logic [WIDTH-1:0] code_d;
    logic [WIDTH-1:0] trial_d;

    // dac_q always carries the committed upper bits plus the bit under test.
    always_comb begin
        code_d  = cmp_bit ? dac_q : (dac_q & ~(ONE << bit_q));
        trial_d = code_d | (ONE << (bit_q - IW'(1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sample_q <= 1'b0;
            cmp_en_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            dac_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_SAMPLE;
                        sample_q <= 1'b1;
                        busy_q   <= 1'b1;
                        dac_q    <= '0;
                        cnt_q    <= SAMPLE_LOAD;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt_q == '0) begin
                        state_q  <= ST_CONV;
                        sample_q <= 1'b0;
                        cmp_en_q <= 1'b1;
                        bit_q    <= TOP_BIT;
                        dac_q    <= MSB_TRIAL;
                        cnt_q    <= HOLD_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_CONV: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (bit_q == '0) begin
                        state_q  <= ST_DONE;
                        cmp_en_q <= 1'b0;
                        dac_q    <= code_d;
                        result_q <= code_d;
                        valid_q  <= 1'b1;
                    end else begin
                        dac_q <= trial_d;
                        bit_q <= bit_q - IW'(1);
                        cnt_q <= HOLD_LOAD;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        dac_q   <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sample       = sample_q;
    assign cmp_en       = cmp_en_q;
    assign dac_code     = dac_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: a behavioural comparator drives cmp_in from dac_code,
// and each step checks latency, trial codes, handshake and reset behaviour against hand-computed values.
module tb_sar_adc_ctrl;

    localparam int W  = 8;
    localparam int SC = 2;
`ifdef SAR_CMP_SYNC_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 2;
`endif
    localparam int LAT = SC + W * HOLD;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         result_ready = 1'b0;
    logic         cmp_in;
    logic         sample, cmp_en, busy, result_valid;
    logic [W-1:0] dac_code, result;

    int           mode = 0;
    logic [W-1:0] target = 8'h5A;
    int           pass_cnt = 0;
    int           total = 0;

    sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .cmp_in(cmp_in),
        .sample(sample), .cmp_en(cmp_en), .dac_code(dac_code), .busy(busy),
        .result(result), .result_valid(result_valid), .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    // Comparator model: 1 means the analog input is at or above the DAC voltage.
    always_comb begin
        cmp_in = 1'b0;
        case (mode)
            1:       cmp_in = 1'b1;
            2:       cmp_in = 1'b0;
            default: cmp_in = (target >= dac_code);
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic conv(input logic [W-1:0] exp, input bit chk_trials);
        logic [W-1:0] trials [8];
        logic [W-1:0] log_q [$];
        int lat;
        trials = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
            if (cmp_en === 1'b1) log_q.push_back(dac_code);
            if (lat == 1) chk("sample_phase", {29'd0, sample, busy, cmp_en}, 32'b110);
        end while (result_valid !== 1'b1 && lat < 300);
        $display("conv target=%0h result=%0h latency=%0d", target, result, lat);
        chk("latency", lat, LAT);
        chk("result", result, exp);
        chk("done_dac", dac_code, exp);
        chk("done_busy_cmp", {30'd0, busy, cmp_en}, 32'b10);
        if (chk_trials) begin
            chk("trial_count", log_q.size(), W * HOLD);
            for (int k = 0; k < W; k++) begin
                chk("trial_first", log_q[k*HOLD], trials[k]);
                chk("trial_last", log_q[k*HOLD + HOLD - 1], trials[k]);
            end
        end
    endtask

    initial begin
        int c, np, idle;
        int vc [3];
        logic prev_v;

        tick();
        tick();
        $display("reset state check");
        chk("rst_ctrl", {28'd0, sample, cmp_en, busy, result_valid}, 0);
        chk("rst_dac", dac_code, 0);
        chk("rst_result", result, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Target 0x5A, ready already high: single-cycle valid, then back to IDLE.
        result_ready = 1'b1;
        mode = 0; target = 8'h5A;
        conv(8'h5A, 1'b1);
        tick();
        chk("xfer_valid", result_valid, 0);
        chk("xfer_busy", busy, 0);
        chk("xfer_dac", dac_code, 0);
        chk("xfer_result_kept", result, 8'h5A);

        // Comparator tied high, then low.
        mode = 1;
        conv(8'hFF, 1'b0);
        tick();
        mode = 2;
        conv(8'h00, 1'b0);
        tick();

        // Consumer stalls for 5 cycles; a start pulse in DONE must be ignored.
        mode = 0; target = 8'h33; result_ready = 1'b0;
        conv(8'h33, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) start = 1'b1;
            tick();
            start = 1'b0;
            $display("stall cycle %0d valid=%0b result=%0h", i, result_valid, result);
            chk("stall_valid", result_valid, 1);
            chk("stall_result", result, 8'h33);
            chk("stall_busy", busy, 1);
        end
        result_ready = 1'b1;
        tick();
        chk("stall_xfer_valid", result_valid, 0);
        chk("stall_xfer_busy", busy, 0);
        tick();
        tick();
        chk("no_queued_start", busy, 0);

        // Reset ten clocks into a conversion, then a clean conversion.
        target = 8'hC7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("mid-conversion reset");
        chk("abort_ctrl", {28'd0, sample, cmp_en, busy, result_valid}, 0);
        chk("abort_dac", dac_code, 0);
        chk("abort_result", result, 0);
        conv(8'hC7, 1'b0);
        tick();

        // start held high: three back-to-back conversions.
        target = 8'h96;
        start = 1'b1;
        tick();
        c = 0; np = 0; idle = 0; prev_v = 1'b0;
        while (np < 3 && c < 3 * (LAT + 2) + 20) begin
            tick();
            c++;
            if (busy === 1'b0) idle++;
            if (result_valid === 1'b1) begin
                if (prev_v) chk("valid_one_cycle", 1, 0);
                $display("b2b result %0d at clock %0d = %0h", np, c, result);
                chk("b2b_result", result, 8'h96);
                vc[np] = c;
                np++;
            end
            prev_v = result_valid;
        end
        tick();
        start = 1'b0;
        chk("b2b_count", np, 3);
        chk("b2b_valid_drop", result_valid, 0);
        chk("b2b_first", vc[0], LAT);
        chk("b2b_spacing1", vc[1] - vc[0], LAT + 2);
        chk("b2b_spacing2", vc[2] - vc[1], LAT + 2);
        chk("b2b_idle_gaps", idle, 2);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
- Successive-approximation controller on the digital side of the on-chip latched comparator.
- Drives a WIDTH-bit trial code to the DAC and reads the comparator decision bit. It binary-searches the code MSB-first and returns the result over a valid/ready handshake.
- Sits between the comparator/DAC pins and the user logic inside the tt_um top.

Parameters:
- WIDTH, 8: conversion resolution in bits; legal range 2..16.
- SAMPLE_CYCLES, 2: length of the track/sample phase in clocks; minimum 1.
- SETTLE_CYCLES, 2: clocks each trial code is held before the comparator is read; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  conversion request, level-sampled.
- cmp_in  in  1  comparator output; 1 = analog input >= DAC voltage.
- sample  out  1  track phase active (drives sample switch).
- cmp_en  out  1  comparator enable, high during conversion phase.
- dac_code  out  WIDTH  trial code to DAC.
- busy  out  1  high from accepted start until the result is transferred.
- result  out  WIDTH  converted code.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.

Behaviour:
- The design has one clock: clk. Reset is synchronous and active-high on rst.
- Reset effect: state IDLE; all outputs 0 (sample, cmp_en, busy, result_valid, dac_code, result).
- States:
  - IDLE -> SAMPLE on an edge with start=1.
  - SAMPLE -> CONV after SAMPLE_CYCLES.
  - CONV -> DONE after WIDTH*SETTLE_CYCLES.
  - DONE -> IDLE on an edge with result_valid & result_ready.
- SAMPLE: sample=1, busy=1, dac_code=0.
- CONV:
  - sample=0, cmp_en=1, busy=1. Bit index i runs WIDTH-1 down to 0.
  - Per bit: dac_code = committed upper bits | (1<<i), lower bits 0, held exactly SETTLE_CYCLES clocks.
  - At the edge ending the last settle clock, cmp_in is sampled: 1 keeps bit i, 0 clears it.
- Latency: result_valid rises SAMPLE_CYCLES + WIDTH*SETTLE_CYCLES clocks after the edge that captured start (18 with defaults).
- DONE:
  - result holds the final code; result_valid=1, busy=1, cmp_en=0.
  - dac_code holds the final code.
  - result and result_valid are stable until transfer.
- Transfer: occurs on an edge with result_valid & result_ready.
  - Next cycle: result_valid=0, busy=0, state IDLE.
  - result keeps its last value until the next DONE.
  - dac_code returns to 0.
- If result_ready is already high when result_valid rises, the transfer occurs at the next edge; result_valid is high for exactly one cycle.
- start is ignored in SAMPLE, CONV and DONE; there is no queuing.
- start held high continuously: a new conversion begins the edge after returning to IDLE.
- result_ready with result_valid=0 is ignored.
- Reset mid-operation aborts the conversion; the partial code is discarded and all outputs return to reset values the next cycle.
- Boundary codes:
  - cmp_in constantly 1 -> result = all ones.
  - cmp_in constantly 0 -> result = 0.
- No arithmetic overflow is possible; the trial register is exactly WIDTH bits.

Optional Feature:
- Macro: SAR_CMP_SYNC_EN.
- Defined:
  - cmp_in passes through a 2-flop synchronizer (reset to 0) before use.
  - Each bit's hold window becomes SETTLE_CYCLES+2 clocks so the decision reflects that bit's trial code.
  - Latency = SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+2); 34 with defaults.
- Undefined: cmp_in is used directly; the latency formula above applies.

Test Plan:
- Comparator model cmp_in = (0x5A >= dac_code), start pulsed one cycle, result_ready=1 -> result_valid high at clock 18, result=0x5A, dac_code trial sequence 0x80,0x40,0x60,0x50,0x58,0x5C,0x5A,0x5B.
- cmp_in tied 1, then tied 0 -> result 0xFF, then 0x00; each takes 18 clocks.
- result_ready held 0 for 5 cycles after valid, start pulsed meanwhile -> result/valid stable, start ignored, busy=1. Ready raised -> valid drops next cycle, busy=0.
- rst asserted at clock 10 of a conversion -> next cycle all outputs 0, state IDLE; a new start yields a correct full conversion.
- start held high for 3 conversions with ready=1 -> back-to-back results, each valid for exactly one cycle; a 1-cycle IDLE gap between each.
- Build with SAR_CMP_SYNC_EN, target 0x5A -> result 0x5A at clock 34; each trial code held 4 clocks.
